multicycle_ctrl: RTL and testbench

- Multi-cycle main control FSM for the MIPS-subset CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the register-file, memory, ALU and PC write enables.
- Configures the immediate extender mode (ext_op) and ALU operand selection per instruction.
- Sits between the instruction register and the datapath. Memory accesses use a ready handshake so the block can stall on slow memory.

---
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the main control FSM and the MIPS-subset datapath/memory.
// The master side is the controller; the slave side is the datapath that feeds it.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_wr;
  logic       ir_wr;
  logic       mem_rd;
  logic       mem_wr;
  logic       i_or_d;
  logic       reg_wr;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src;
  logic [2:0] alu_op;
  logic [1:0] ext_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic       bus_err;
  logic [2:0] state;

  // Handshake: a memory request (mem_rd or mem_wr) stays high until the cycle
  // mem_ready is seen; that cycle completes the access. No data moves otherwise.
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_wr, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, pc_src, illegal, bus_err, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_wr, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr, reg_dst, mem_to_reg,
           alu_src, alu_op, ext_op, pc_src, illegal, bus_err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset CPU: FETCH, DECODE, EXEC,
// MEM and WB, with a bounded wait on memory that aborts with bus_err.
module multicycle_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE, C_ORI, C_ADDIU, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILLEGAL
  } cls_t;

  state_t     r_state, w_next;
  cls_t       r_cls, w_cls;
  logic [2:0] r_rop, w_rop;
  logic [1:0] r_ext, w_ext_dec;
  logic [7:0] r_tmo;
  logic       w_waiting, w_abort;

  logic       w_pc_wr, w_ir_wr, w_mem_rd, w_mem_wr, w_i_or_d, w_reg_wr;
  logic       w_reg_dst, w_mem_to_reg, w_alu_src, w_illegal, w_bus_err;
  logic [2:0] w_alu_op, w_state;
  logic [1:0] w_ext_op, w_pc_src;

  // Instruction class decode, straight from the instruction register fields.
  always_comb begin
    w_cls     = C_ILLEGAL;
    w_rop     = 3'b000;
    w_ext_dec = 2'b01;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100001: begin w_cls = C_RTYPE; w_rop = 3'b000; end
          6'b100011: begin w_cls = C_RTYPE; w_rop = 3'b001; end
          6'b101010: begin w_cls = C_RTYPE; w_rop = 3'b011; end
          default:   w_cls = C_ILLEGAL;
        endcase
      end
      6'b001101: begin w_cls = C_ORI; w_ext_dec = 2'b00; end
      6'b001001: w_cls = C_ADDIU;
      6'b001111: begin w_cls = C_LUI; w_ext_dec = 2'b10; end
      6'b100011: w_cls = C_LW;
      6'b101011: w_cls = C_SW;
      6'b000100: w_cls = C_BEQ;
      6'b000010: w_cls = C_J;
      default:   w_cls = C_ILLEGAL;
    endcase
  end

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_abort   = w_waiting && (r_tmo == MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cls   <= C_RTYPE;
      r_rop   <= 3'b000;
      r_ext   <= 2'b01;
      r_tmo   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_cls != C_ILLEGAL) begin
        r_cls <= w_cls;
        r_rop <= w_rop;
        r_ext <= w_ext_dec;
      end
      if (w_waiting && !w_abort && !bus.mem_ready)
        r_tmo <= r_tmo + 8'd1;
      else
        r_tmo <= 8'd0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pc_wr      = 1'b0;
    w_ir_wr      = 1'b0;
    w_mem_rd     = 1'b0;
    w_mem_wr     = 1'b0;
    w_i_or_d     = 1'b0;
    w_reg_wr     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_alu_op     = 3'b000;
    w_ext_op     = r_ext;
    w_pc_src     = 2'b00;
    w_illegal    = 1'b0;
    w_bus_err    = 1'b0;
    w_state      = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_abort) begin
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_mem_rd = 1'b1;
          if (bus.mem_ready) begin
            w_ir_wr = 1'b1;
            w_pc_wr = 1'b1;
            w_next  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        w_ext_op = w_ext_dec;
        if (w_cls == C_ILLEGAL) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_WB;
        case (r_cls)
          C_RTYPE: w_alu_op = r_rop;
          C_ORI:   begin w_alu_op = 3'b010; w_alu_src = 1'b1; end
          C_ADDIU: begin w_alu_op = 3'b000; w_alu_src = 1'b1; end
          C_LUI:   begin w_alu_op = 3'b100; w_alu_src = 1'b1; end
          C_LW, C_SW: begin
            w_alu_op  = 3'b000;
            w_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          C_BEQ: begin
            w_alu_op = 3'b001;
            w_pc_src = 2'b01;
            w_pc_wr  = bus.zero;
            w_next   = S_FETCH;
          end
          C_J: begin
            w_pc_src = 2'b10;
            w_pc_wr  = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_i_or_d = 1'b1;
        if (w_abort) begin
          w_bus_err = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_mem_rd = (r_cls == C_LW);
          w_mem_wr = (r_cls == C_SW);
          if (bus.mem_ready)
            w_next = (r_cls == C_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        w_reg_wr     = 1'b1;
        w_reg_dst    = (r_cls == C_RTYPE);
        w_mem_to_reg = (r_cls == C_LW);
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset quiets every output, so a pending mem_ready cannot write IR or PC.
    if (rst) begin
      w_pc_wr      = 1'b0;
      w_ir_wr      = 1'b0;
      w_mem_rd     = 1'b0;
      w_mem_wr     = 1'b0;
      w_i_or_d     = 1'b0;
      w_reg_wr     = 1'b0;
      w_reg_dst    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_alu_src    = 1'b0;
      w_alu_op     = 3'b000;
      w_ext_op     = 2'b01;
      w_pc_src     = 2'b00;
      w_illegal    = 1'b0;
      w_bus_err    = 1'b0;
      w_state      = S_FETCH;
    end
  end

  assign bus.pc_wr      = w_pc_wr;
  assign bus.ir_wr      = w_ir_wr;
  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.i_or_d     = w_i_or_d;
  assign bus.reg_wr     = w_reg_wr;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src    = w_alu_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.ext_op     = w_ext_op;
  assign bus.pc_src     = w_pc_src;
  assign bus.illegal    = w_illegal;
  assign bus.bus_err    = w_bus_err;
  assign bus.state      = w_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level schedule model fills an
// expected queue per cycle; literal checks pin lengths and pulse counts.
module tb_multicycle_ctrl;

  localparam int W   = 21;
  localparam int TMO = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_wr, ir_wr, mem_rd, mem_wr, i_or_d, reg_wr, reg_dst, mem_to_reg, alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op, pc_src;
    logic       illegal, bus_err;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        tag_q[$];
  int n_checks = 0;
  int n_err    = 0;
  string cur_tag = "reset";
  logic [1:0] m_ext = 2'b01;
  bit m_post_rst = 1'b1;
  int busy, n_mrd_mem, n_mwr, n_pcx, n_ill, n_rw, n_be;

  function automatic logic [W-1:0] mask_of(ov_t e, bit st_c, bit ext_c, bit alu_c);
    ov_t m;
    m = '1;
    if (!st_c) m.st = '0;
    if (!ext_c) m.ext_op = '0;
    if (e.st != 3'd2 || !alu_c) begin m.alu_op = '0; m.alu_src = 1'b0; end
    if (!e.pc_wr) m.pc_src = '0;
    if (e.st != 3'd4) begin m.reg_dst = 1'b0; m.mem_to_reg = 1'b0; end
    if (e.st != 3'd0 && e.st != 3'd3) m.i_or_d = 1'b0;
    return m;
  endfunction

  // Compare process: every cycle with a queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] act, ex, mk;
    string tg;
    act = {bus.state, bus.pc_wr, bus.ir_wr, bus.mem_rd, bus.mem_wr, bus.i_or_d, bus.reg_wr,
           bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.alu_op, bus.ext_op, bus.pc_src,
           bus.illegal, bus.bus_err};
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      mk = msk_q.pop_front();
      tg = tag_q.pop_front();
      n_checks++;
      if ((act & mk) !== (ex & mk)) begin
        n_err++;
        $display("FAIL cycle[%s] outputs got %h expected %h (care %h) at %0t", tg, act, ex, mk, $time);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.state != 3'd0) busy++;
      if (bus.state == 3'd3 && bus.mem_rd) n_mrd_mem++;
      if (bus.mem_wr) n_mwr++;
      if (bus.state == 3'd2 && bus.pc_wr) n_pcx++;
      if (bus.illegal) n_ill++;
      if (bus.reg_wr) n_rw++;
      if (bus.bus_err) n_be++;
    end
  end

  task automatic lit(input string nm, input int act, input int ex);
    n_checks++;
    if (act != ex) begin
      n_err++;
      $display("FAIL lit[%s] got %0d expected %0d", nm, act, ex);
    end
  endtask

  task automatic step_a(input logic rdy, input logic r, input ov_t e,
                        input bit st_c, input bit ext_c, input bit alu_c);
    bus.mem_ready = rdy;
    rst = r;
    exp_q.push_back(e);
    msk_q.push_back(mask_of(e, st_c, ext_c, alu_c));
    tag_q.push_back(cur_tag);
    @(negedge clk);
    #1;
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rdy, input ov_t e, input bit ext_c, input bit alu_c);
    step_a(rdy, 1'b0, e, 1'b1, ext_c, alu_c);
    step_b();
  endtask

  task automatic clear_counts();
    busy = 0; n_mrd_mem = 0; n_mwr = 0; n_pcx = 0; n_ill = 0; n_rw = 0; n_be = 0;
  endtask

  task automatic reset_cycle();
    ov_t e;
    e = '0;
    e.ext_op = 2'b01;
    step_a(1'b1, 1'b1, e, 1'b0, 1'b1, 1'b1);
    step_b();
    m_ext = 2'b01;
    m_post_rst = 1'b1;
  endtask

  // First cycle out of reset: FETCH requesting, nothing else active.
  task automatic post_reset_check(input string tag);
    ov_t e;
    cur_tag = tag;
    e = '0;
    e.mem_rd = 1'b1;
    e.ext_op = 2'b01;
    step_a(1'b0, 1'b0, e, 1'b1, 1'b1, 1'b1);
    lit({tag, "_state"}, bus.state, 0);
    lit({tag, "_mem_wr"}, bus.mem_wr, 0);
    lit({tag, "_ext_op"}, bus.ext_op, 1);
    lit({tag, "_reg_wr"}, bus.reg_wr, 0);
    step_b();
    m_post_rst = 1'b0;
  endtask

  // Schedule of one instruction: fwait/mwait are memory wait cycles, mwait < 0
  // means memory never answers; rst_in_mem pulses reset after 2 MEM cycles.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fwait, input int mwait, input bit rst_in_mem);
    ov_t e;
    bit leg, rt, ld, sw, br, jp;
    logic [2:0] aop;
    logic asrc;
    logic [1:0] ext;
    cur_tag = tag;
    bus.opcode = op;
    bus.funct = fn;
    bus.zero = z;
    clear_counts();
    leg = 1; rt = 0; ld = 0; sw = 0; br = 0; jp = 0; aop = 3'b000; asrc = 1; ext = 2'b01;
    case (op)
      6'h00: begin
        rt = 1; asrc = 0;
        if (fn == 6'h21) aop = 3'b000;
        else if (fn == 6'h23) aop = 3'b001;
        else if (fn == 6'h2a) aop = 3'b011;
        else leg = 0;
      end
      6'h0d: begin ext = 2'b00; aop = 3'b010; end
      6'h09: aop = 3'b000;
      6'h0f: begin ext = 2'b10; aop = 3'b100; end
      6'h23: ld = 1;
      6'h2b: sw = 1;
      6'h04: begin br = 1; aop = 3'b001; asrc = 0; end
      6'h02: jp = 1;
      default: leg = 0;
    endcase
    for (int k = 0; k < fwait; k++) begin
      e = '0; e.mem_rd = 1; e.ext_op = m_ext;
      step(1'b0, e, m_post_rst, 1'b1);
      m_post_rst = 1'b0;
    end
    e = '0; e.mem_rd = 1; e.ir_wr = 1; e.pc_wr = 1; e.ext_op = m_ext;
    step(1'b1, e, m_post_rst, 1'b1);
    m_post_rst = 1'b0;
    e = '0; e.st = 3'd1; e.illegal = !leg; e.ext_op = leg ? ext : m_ext;
    step(1'b0, e, leg, 1'b1);
    if (!leg) return;
    m_ext = ext;
    e = '0; e.st = 3'd2; e.ext_op = m_ext; e.alu_op = aop; e.alu_src = asrc;
    if (br) begin e.pc_wr = z; e.pc_src = 2'b01; end
    if (jp) begin e.pc_wr = 1; e.pc_src = 2'b10; end
    step(1'b0, e, 1'b1, !jp);
    if (br || jp) return;
    if (ld || sw) begin
      e = '0; e.st = 3'd3; e.i_or_d = 1; e.mem_rd = ld; e.mem_wr = sw; e.ext_op = m_ext;
      if (mwait < 0) begin
        for (int k = 0; k < TMO; k++) step(1'b0, e, 1'b1, 1'b1);
        e.mem_rd = 0; e.mem_wr = 0; e.bus_err = 1;
        step(1'b0, e, 1'b1, 1'b1);
        return;
      end
      if (rst_in_mem) begin
        for (int k = 0; k < 2; k++) step(1'b0, e, 1'b1, 1'b1);
        reset_cycle();
        return;
      end
      for (int k = 0; k < mwait; k++) step(1'b0, e, 1'b1, 1'b1);
      step(1'b1, e, 1'b1, 1'b1);
      if (sw) return;
    end
    e = '0; e.st = 3'd4; e.reg_wr = 1; e.reg_dst = rt; e.mem_to_reg = ld; e.ext_op = m_ext;
    step(1'b0, e, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    clear_counts();
    @(posedge clk); #1;
    reset_cycle();
    reset_cycle();
    post_reset_check("rst0");

    run_instr("ori", 6'h0d, 6'h00, 1'b0, 0, 0, 0);
    lit("ori_len", busy + 1, 4);
    lit("ori_regwr", n_rw, 1);
    run_instr("lui", 6'h0f, 6'h00, 1'b0, 0, 0, 0);
    lit("lui_len", busy + 1, 4);
    run_instr("lw_slow", 6'h23, 6'h00, 1'b0, 0, 3, 0);
    lit("lw_len", busy + 1, 8);
    lit("lw_memrd_cycles", n_mrd_mem, 4);
    lit("lw_regwr", n_rw, 1);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0, 0);
    lit("beq1_len", busy + 1, 3);
    lit("beq1_pcwr", n_pcx, 1);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 0, 0, 0);
    lit("beq0_len", busy + 1, 3);
    lit("beq0_pcwr", n_pcx, 0);
    run_instr("j", 6'h02, 6'h00, 1'b0, 0, 0, 0);
    lit("j_len", busy + 1, 3);
    run_instr("addu_fw", 6'h00, 6'h21, 1'b0, 2, 0, 0);
    run_instr("subu", 6'h00, 6'h23, 1'b1, 0, 0, 0);
    lit("subu_len", busy + 1, 4);
    run_instr("slt", 6'h00, 6'h2a, 1'b0, 0, 0, 0);
    run_instr("addiu", 6'h09, 6'h3f, 1'b0, 0, 0, 0);
    run_instr("lw", 6'h23, 6'h00, 1'b0, 0, 0, 0);
    lit("lw0_len", busy + 1, 5);
    run_instr("sw", 6'h2b, 6'h00, 1'b0, 0, 1, 0);
    lit("sw_mwr", n_mwr, 2);
    run_instr("sw0", 6'h2b, 6'h00, 1'b0, 0, 0, 0);
    lit("sw_len", busy + 1, 4);
    run_instr("ill_op", 6'h3f, 6'h00, 1'b0, 0, 0, 0);
    lit("ill_pulses", n_ill, 1);
    lit("ill_regwr", n_rw, 0);
    lit("ill_memwr", n_mwr, 0);
    lit("ill_len", busy + 1, 2);
    run_instr("ill_fn", 6'h00, 6'h00, 1'b0, 0, 0, 0);
    lit("illfn_pulses", n_ill, 1);
    run_instr("sw_tmo", 6'h2b, 6'h00, 1'b0, 0, -1, 0);
    lit("tmo_buserr", n_be, 1);
    lit("tmo_memwr", n_mwr, 4);
    lit("tmo_len", busy + 1, 8);
    run_instr("ori_after_tmo", 6'h0d, 6'h00, 1'b0, 0, 0, 0);
    run_instr("sw_rst", 6'h2b, 6'h00, 1'b0, 0, 5, 1);
    lit("rst_mid_regwr", n_rw, 0);
    post_reset_check("rst_mid");
    run_instr("addu_after_rst", 6'h00, 6'h21, 1'b0, 0, 0, 0);
    lit("addu_len", busy + 1, 4);

    step_b();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
